picomem_uart_dbg_master: RTL and testbench
==========================================

// Module: picomem_uart_dbg_master
// PURPOSE
//  UART-driven debug initiator on the PicoMem bus: the master end of the valid/ready protocol the CPU drives.
//  Decodes 8N1 byte commands from a host, issues single-word PicoMem reads/writes, returns results over UART.
//  Sits as a second initiator ahead of the 1:4 address mux (external arbiter) for boot-SRAM loading and peripheral poking.
// PARAMETERS
//  CLK_DIV      234   clk cycles per UART bit (27 MHz / 115200); legal >= 8
//  BUS_TIMEOUT  1024  cycles mem_m_valid may wait for ready (used only with DBGM_TIMEOUT_EN)
// PORTS
//  clk          in   1   core clock; all logic rising-edge
//  reset        in   1   synchronous, active-high reset
//  ser_rx       in   1   UART receive, async, idle high
//  ser_tx       out  1   UART transmit, idle high
//  mem_m_valid  out  1   PicoMem request valid
//  mem_m_ready  in   1   PicoMem responder ready (transfer completes in this cycle)
//  mem_m_addr   out  32  word address, [1:0] always 0
//  mem_m_wdata  out  32  write data
//  mem_m_wstrb  out  4   4'hF write, 4'h0 read
//  mem_m_rdata  in   32  read data, sampled when valid&&ready
//  busy         out  1   command in progress
// BEHAVIOUR
//  Reset: ser_tx=1, mem_m_valid=0, mem_m_addr/wdata=0, mem_m_wstrb=0, busy=0; all FSMs IDLE; counters 0.
//  RX: ser_rx through 2-flop synchroniser. Falling edge in idle starts a frame; re-check at CLK_DIV/2, high -> abort
//   (glitch). Data sampled every CLK_DIV, LSB first; stop bit sampled; stop=0 -> framing error: byte discarded, cmd FSM -> IDLE.
//  Commands (multi-byte fields big-endian):
//   0x57 'W' + addr[4] + data[4] -> write; response 0x06.
//   0x52 'R' + addr[4]           -> read;  response rdata[31:24],[23:16],[15:8],[7:0].
//   any other first byte         -> no bus access; response 0x15.
//  Cmd FSM: IDLE -> ADDR (4 bytes) -> DATA (4 bytes, W only) -> BUS -> RESP -> IDLE.
//  BUS: mem_m_valid rises the cycle after the last command byte's stop bit is accepted; addr/wdata/wstrb held
//   stable while valid; in the valid&&ready cycle rdata is captured, valid drops next cycle (exactly one transfer).
//  Address bits [1:0] from host are ignored (forced 0).
//  RESP: bytes sent back-to-back, 1 start + 8 data LSB-first + 1 stop, each bit CLK_DIV cycles.
//  busy=1 from the cycle a valid command byte is accepted until the final response stop bit completes.
//  Bytes received in BUS/RESP are discarded (no RX buffering); host must wait for the response.
//  No inter-byte timeout: a partial command waits indefinitely; only framing error or reset clears it.
//  Reset mid-operation: next cycle valid=0, ser_tx=1, partial command and response dropped.
// CONFIGURATION
//  DBGM_TIMEOUT_EN defined: a counter starts with mem_m_valid; if ready has not arrived after BUS_TIMEOUT
//   cycles, valid drops and the single response byte 0x15 is sent (for W and R alike); counter clears per access.
//  DBGM_TIMEOUT_EN undefined: no counter; BUS waits for mem_m_ready indefinitely; BUS_TIMEOUT unused.
// TESTING
//  1 Write: RX 57 40 00 00 10 DE AD BE EF -> one transfer addr 0x40000010, wdata 0xDEADBEEF, wstrb F; TX 06.
//  2 Read, ready 3 cycles after valid, rdata 0x12345678: RX 52 80 00 00 00 -> wstrb 0, TX 12 34 56 78.
//  3 Unknown cmd: RX 41 -> no mem_m_valid ever; TX 15; following valid W command executes normally.
//  4 Framing error (stop=0) on 2nd addr byte -> FSM IDLE, no bus access, no TX; subsequent command accepted.
//  5 DBGM_TIMEOUT_EN, ready held 0 -> valid drops after BUS_TIMEOUT cycles, TX 15; without macro valid stays high.
//  6 Reset during BUS with valid high -> next cycle valid=0, ser_tx=1, busy=0; 2-cycle start glitch ignored.

Source files
------------

// File: rtl/picomem_uart_dbg_master_if.sv
// PicoMem single-initiator bus bundle: valid/ready handshake, word address,
// write data/strobes and read data.
interface picomem_uart_dbg_master_if;
  logic        mem_m_valid;
  logic        mem_m_ready;
  logic [31:0] mem_m_addr;
  logic [31:0] mem_m_wdata;
  logic [3:0]  mem_m_wstrb;
  logic [31:0] mem_m_rdata;

  modport master (
    output mem_m_valid, mem_m_addr, mem_m_wdata, mem_m_wstrb,
    input  mem_m_ready, mem_m_rdata
  );

  modport slave (
    input  mem_m_valid, mem_m_addr, mem_m_wdata, mem_m_wstrb,
    output mem_m_ready, mem_m_rdata
  );
endinterface

// File: rtl/picomem_uart_dbg_master.sv
// UART (8N1) debug initiator issuing single-word PicoMem reads/writes.
// Optional bus-timeout abort enabled with `define DBGM_TIMEOUT_EN.
module picomem_uart_dbg_master #(
  parameter int unsigned CLK_DIV     = 234,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ser_rx,
  output logic                              ser_tx,
  picomem_uart_dbg_master_if.master         mem,
  output logic                              busy
);

  if (CLK_DIV < 8 || BUS_TIMEOUT == 0) begin : g_bad_param
    $error("picomem_uart_dbg_master: CLK_DIV must be >= 8 and BUS_TIMEOUT > 0");
  end

  localparam int unsigned CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_vld_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= ser_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_vld_q   <= rx_vld_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_vld_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start re-check: a line back high here was a glitch
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_vld_d   = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- command / bus / response ----------------
  typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_BUS, C_RESP} cmd_state_e;

  cmd_state_e    st_q, st_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic [9:0]    txf_q, txf_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
`ifdef DBGM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= C_IDLE;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      nbytes_q <= '0;
      txf_q    <= '1;
      tx_bit_q <= '0;
      tx_cnt_q <= '0;
`ifdef DBGM_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      st_q     <= st_d;
      is_wr_q  <= is_wr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      nbytes_q <= nbytes_d;
      txf_q    <= txf_d;
      tx_bit_q <= tx_bit_d;
      tx_cnt_q <= tx_cnt_d;
`ifdef DBGM_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    st_d     = st_q;
    is_wr_d  = is_wr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    nbytes_d = nbytes_q;
    txf_d    = txf_q;
    tx_bit_d = tx_bit_q;
    tx_cnt_d = tx_cnt_q;
`ifdef DBGM_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (st_q)
      C_IDLE: begin
        if (rx_vld_q) begin
          if (rx_sh_q == CMD_W || rx_sh_q == CMD_R) begin
            is_wr_d = (rx_sh_q == CMD_W);
            idx_d   = '0;
            st_d    = C_ADDR;
          end else begin
            resp_d   = {RSP_NAK, 24'h0};
            nbytes_d = 3'd1;
            txf_d    = frame(RSP_NAK);
            tx_bit_d = '0;
            tx_cnt_d = '0;
            st_d     = C_RESP;
          end
        end
      end
      C_ADDR, C_DATA: begin
        if (rx_ferr_q) begin
          st_d = C_IDLE;
        end else if (rx_vld_q) begin
          if (st_q == C_ADDR) addr_d  = {addr_q[23:0], rx_sh_q};
          else                wdata_d = {wdata_q[23:0], rx_sh_q};
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            st_d = (st_q == C_ADDR && is_wr_q) ? C_DATA : C_BUS;
`ifdef DBGM_TIMEOUT_EN
            tmo_d = '0;
`endif
          end
        end
      end
      C_BUS: begin
        tx_bit_d = '0;
        tx_cnt_d = '0;
        if (mem.mem_m_ready) begin
          resp_d   = is_wr_q ? {RSP_ACK, 24'h0} : mem.mem_m_rdata;
          nbytes_d = is_wr_q ? 3'd1 : 3'd4;
          txf_d    = frame(is_wr_q ? RSP_ACK : mem.mem_m_rdata[31:24]);
          st_d     = C_RESP;
        end
`ifdef DBGM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          resp_d   = {RSP_NAK, 24'h0};
          nbytes_d = 3'd1;
          txf_d    = frame(RSP_NAK);
          st_d     = C_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      C_RESP: begin
        // Next byte is loaded in the same cycle the stop bit ends: no idle gap
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            nbytes_d = nbytes_q - 1'b1;
            resp_d   = {resp_q[23:0], 8'h00};
            txf_d    = frame(resp_q[23:16]);
            if (nbytes_q == 3'd1) begin
              txf_d = '1;
              st_d  = C_IDLE;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            txf_d    = {1'b1, txf_q[9:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: st_d = C_IDLE;
    endcase
  end

  assign ser_tx          = (st_q == C_RESP) ? txf_q[0] : 1'b1;
  assign busy            = (st_q != C_IDLE);
  assign mem.mem_m_valid = (st_q == C_BUS);
  assign mem.mem_m_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_m_wdata = wdata_q;
  assign mem.mem_m_wstrb = (st_q == C_BUS && is_wr_q) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_picomem_uart_dbg_master.sv
// Directed bench for picomem_uart_dbg_master: UART host model, PicoMem
// responder and TX byte decoder with hand-computed expectations.
module tb_picomem_uart_dbg_master;
  localparam int unsigned CLK_DIV     = 16;
  localparam int unsigned BUS_TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_rx = 1'b1;
  logic ser_tx;
  logic busy;

  picomem_uart_dbg_master_if bus ();

  picomem_uart_dbg_master #(.CLK_DIV(CLK_DIV), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_rx (ser_rx),
    .ser_tx (ser_tx),
    .mem    (bus.master),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // PicoMem responder: ready asserted after ready_dly observed valid cycles
  int  ready_dly = 0;
  int  wcnt = 0;
  bit  resp_en = 1'b1;
  int  xfer_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  initial begin
    bus.mem_m_ready = 1'b0;
    bus.mem_m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_m_ready) begin
        bus.mem_m_ready = 1'b0;
        wcnt = 0;
      end else if (resp_en && bus.mem_m_valid) begin
        if (wcnt >= ready_dly) bus.mem_m_ready = 1'b1;
        else wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_m_valid && bus.mem_m_ready) begin
      xfer_cnt++;
      cap_addr  = bus.mem_m_addr;
      cap_wdata = bus.mem_m_wdata;
      cap_wstrb = bus.mem_m_wstrb;
    end
  end

  // UART TX decoder
  logic [7:0] tx_q[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!ser_tx && !reset) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        chk("tx_stop", {31'h0, ser_tx}, 32'h1);
        tx_q.push_back(b);
      end
    end
  end

  task automatic bit_time();
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    ser_rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      bit_time();
    end
    ser_rx = stop_bit;
    bit_time();
    ser_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic expect_tx(input string tag, input logic [31:0] exp, input int n);
    int budget;
    budget = (n + 2) * 10 * CLK_DIV + 200;
    while (tx_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_nbytes"}, tx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (tx_q.size() > 0) chk({tag, "_byte"}, {24'h0, tx_q.pop_front()}, {24'h0, exp[8*(n-1-i) +: 8]});
    end
    budget = 4 * CLK_DIV;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_valid(input string tag);
    int budget;
    budget = 20 * CLK_DIV;
    while (!bus.mem_m_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_valid_seen"}, {31'h0, bus.mem_m_valid}, 32'h1);
  endtask

  int x0;

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
    chk("rst_valid",  {31'h0, bus.mem_m_valid}, 32'h0);
    chk("rst_addr",   bus.mem_m_addr, 32'h0);
    chk("rst_wdata",  bus.mem_m_wdata, 32'h0);
    chk("rst_wstrb",  {28'h0, bus.mem_m_wstrb}, 32'h0);
    chk("rst_busy",   {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 1: write
    ready_dly = 0;
    x0 = xfer_cnt;
    send_byte(8'h57, 1'b1);
    @(negedge clk);
    chk("wr_busy_first", {31'h0, busy}, 32'h1);
    send_cmd(72'h40000010DEADBEEF, 8);
    expect_tx("wr_resp", 32'h06, 1);
    chk("wr_xfers", xfer_cnt - x0, 1);
    chk("wr_addr",  cap_addr, 32'h40000010);
    chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", {28'h0, cap_wstrb}, 32'hF);

    // 2: read, ready delayed, host address low bits ignored
    ready_dly = 3;
    bus.mem_m_rdata = 32'h12345678;
    x0 = xfer_cnt;
    send_cmd(72'h5280000003, 5);
    expect_tx("rd_resp", 32'h12345678, 4);
    chk("rd_xfers", xfer_cnt - x0, 1);
    chk("rd_addr",  cap_addr, 32'h80000000);
    chk("rd_wstrb", {28'h0, cap_wstrb}, 32'h0);

    // 3: unknown command, then a normal write
    ready_dly = 0;
    x0 = xfer_cnt;
    send_byte(8'h41, 1'b1);
    expect_tx("unk_resp", 32'h15, 1);
    chk("unk_xfers", xfer_cnt - x0, 0);
    send_cmd(72'h570000002311223344, 9);
    expect_tx("unk_wr_resp", 32'h06, 1);
    chk("unk_wr_xfers", xfer_cnt - x0, 1);
    chk("unk_wr_addr",  cap_addr, 32'h00000020);
    chk("unk_wr_wdata", cap_wdata, 32'h11223344);

    // 4: framing error on 2nd address byte
    x0 = xfer_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b0);
    repeat (12 * CLK_DIV) @(posedge clk);
    @(negedge clk);
    chk("fe_busy",   {31'h0, busy}, 32'h0);
    chk("fe_ntx",    tx_q.size(), 0);
    chk("fe_xfers",  xfer_cnt - x0, 0);
    bus.mem_m_rdata = 32'hA5A55A5A;
    @(posedge clk);
    #1;
    send_cmd(72'h5200000004, 5);
    expect_tx("fe_rd_resp", 32'hA5A55A5A, 4);
    chk("fe_rd_addr", cap_addr, 32'h00000004);

    // 5: responder stalls
    resp_en = 1'b0;
    x0 = xfer_cnt;
    send_cmd(72'h570000000800000001, 9);
`ifdef DBGM_TIMEOUT_EN
    expect_tx("tmo_resp", 32'h15, 1);
    chk("tmo_valid", {31'h0, bus.mem_m_valid}, 32'h0);
    chk("tmo_xfers", xfer_cnt - x0, 0);
    send_cmd(72'h5200000000, 5);
`endif
    wait_valid("stall");
    repeat (BUS_TIMEOUT + 40) @(posedge clk);
    @(negedge clk);
`ifndef DBGM_TIMEOUT_EN
    chk("stall_valid", {31'h0, bus.mem_m_valid}, 32'h1);
    chk("stall_busy",  {31'h0, busy}, 32'h1);
    chk("stall_ntx",   tx_q.size(), 0);
`endif
    chk("stall_xfers", xfer_cnt - x0, 0);

    // 6: reset while (possibly) in BUS, then a start glitch
`ifdef DBGM_TIMEOUT_EN
    tx_q.delete();
    send_cmd(72'h5200000000, 5);
    wait_valid("rst");
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid",  {31'h0, bus.mem_m_valid}, 32'h0);
    chk("midrst_ser_tx", {31'h0, ser_tx}, 32'h1);
    chk("midrst_busy",   {31'h0, busy}, 32'h0);
    tx_q.delete();
    resp_en = 1'b1;
    wcnt = 0;
    @(posedge clk);
    #1;
    ser_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ser_rx = 1'b1;
    repeat (12 * CLK_DIV) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", {31'h0, busy}, 32'h0);
    chk("glitch_ntx",  tx_q.size(), 0);
    send_byte(8'h7E, 1'b1);
    expect_tx("post_glitch", 32'h15, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
